// File: rtl/adc_capture_packer.sv
// ADC DDR capture: lane pairing, decimation, word packing and arm/trigger record control.
// Define ADC_TEST_PATTERN_EN to add the tp_sel input and an internal ramp sample source.
module adc_capture_packer #(
    parameter int  SAMPLE_W   = 8,
    parameter int  PAIRS      = 4,
    parameter bit  PAIR_ALIGN = 1'b1,
    parameter int  LEN_W      = 16,
    parameter int  DECIM_W    = 4,
    localparam int OUT_W      = 2 * SAMPLE_W * PAIRS
) (
    input  logic                dco,
    input  logic                rst,
    input  logic [SAMPLE_W-1:0] dr,
    input  logic [SAMPLE_W-1:0] df,
    input  logic                arm,
    input  logic                abort,
    input  logic                trig,
    input  logic [LEN_W-1:0]    rec_len,
    input  logic [DECIM_W-1:0]  decim,
    input  logic                wr_full,
`ifdef ADC_TEST_PATTERN_EN
    input  logic                tp_sel,
`endif
    output logic [OUT_W-1:0]    wr_data,
    output logic                wr_en,
    output logic                busy,
    output logic                done,
    output logic                overflow,
    output logic [LEN_W-1:0]    word_cnt
);
    localparam int PAIR_W = 2 * SAMPLE_W;
    localparam int PCNT_W = (PAIRS > 1) ? $clog2(PAIRS) : 1;
    localparam logic [PCNT_W-1:0] PCNT_LAST = PCNT_W'(PAIRS - 1);

    typedef enum logic [1:0] {S_IDLE, S_ARMED, S_CAPTURE, S_DONE} state_t;

    logic [SAMPLE_W-1:0] s_dr;
    logic [SAMPLE_W-1:0] s_df;

`ifdef ADC_TEST_PATTERN_EN
    logic [SAMPLE_W-1:0] ramp;

    always_ff @(posedge dco or posedge rst) begin
        if (rst) ramp <= '0;
        else     ramp <= ramp + SAMPLE_W'(2);
    end

    assign s_df = tp_sel ? ramp : df;
    assign s_dr = tp_sel ? ramp + 1'b1 : dr;
`else
    assign s_df = df;
    assign s_dr = dr;
`endif

    state_t              state;
    logic                arm_d;
    logic [SAMPLE_W-1:0] df_d;
    logic [PAIR_W-1:0]   pair;
    logic [OUT_W-1:0]    pack;
    logic [PCNT_W-1:0]   pcnt;
    logic [PCNT_W-1:0]   pcnt_base;
    logic [DECIM_W-1:0]  dcnt;
    logic [DECIM_W-1:0]  cur_decim;
    logic                emit_pend;
    logic                arm_rise;
    logic                start;
    logic                accept;
    logic [LEN_W-1:0]    word_cnt_inc;

    assign pair         = PAIR_ALIGN ? {s_dr, df_d} : {s_dr, s_df};
    assign arm_rise     = arm & ~arm_d;
    assign start        = (state == S_ARMED) & trig;
    assign accept       = start | ((state == S_CAPTURE) & (dcnt == '0));
    assign pcnt_base    = start ? '0 : pcnt;
    assign word_cnt_inc = word_cnt + 1'b1;

    always_ff @(posedge dco or posedge rst) begin
        if (rst) begin
            state     <= S_IDLE;
            arm_d     <= 1'b0;
            df_d      <= '0;
            pack      <= '0;
            pcnt      <= '0;
            dcnt      <= '0;
            cur_decim <= '0;
            emit_pend <= 1'b0;
            wr_data   <= '0;
            wr_en     <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            overflow  <= 1'b0;
            word_cnt  <= '0;
        end else begin
            arm_d     <= arm;
            df_d      <= s_df;
            // NOTE: strobes default low here; a later non-blocking assignment in this block overrides.
            wr_en     <= 1'b0;
            emit_pend <= 1'b0;
            if (abort) begin
                state <= S_IDLE;
                busy  <= 1'b0;
                done  <= 1'b0;
                pcnt  <= '0;
            end else begin
                if (accept) begin
                    // New pairs enter at the top, so a full word holds its oldest pair in the LSBs.
                    pack <= (pack >> PAIR_W) | (OUT_W'(pair) << (OUT_W - PAIR_W));
                    if (pcnt_base == PCNT_LAST) begin
                        pcnt      <= '0;
                        emit_pend <= 1'b1;
                    end else begin
                        pcnt <= pcnt_base + 1'b1;
                    end
                end
                if (start) begin
                    dcnt      <= (decim == '0) ? '0 : DECIM_W'(1);
                    cur_decim <= decim;
                end else if (dcnt == cur_decim) begin
                    dcnt      <= '0;
                    cur_decim <= decim;
                end else begin
                    dcnt <= dcnt + 1'b1;
                end
                case (state)
                    S_IDLE: begin
                        if (arm_rise) begin
                            state <= S_ARMED;
                            busy  <= 1'b1;
                        end
                    end
                    S_ARMED: begin
                        if (trig) begin
                            state    <= S_CAPTURE;
                            word_cnt <= '0;
                        end
                    end
                    S_CAPTURE: begin
                        if (emit_pend) begin
                            word_cnt <= word_cnt_inc;
                            if (wr_full) begin
                                overflow <= 1'b1;
                            end else begin
                                wr_en   <= 1'b1;
                                wr_data <= pack;
                            end
                            if ((rec_len != '0) && (word_cnt_inc == rec_len)) begin
                                state <= S_DONE;
                                busy  <= 1'b0;
                                done  <= 1'b1;
                            end
                        end
                    end
                    S_DONE: begin
                        if (arm_rise) begin
                            state    <= S_ARMED;
                            busy     <= 1'b1;
                            done     <= 1'b0;
                            overflow <= 1'b0;
                        end
                    end
                    default: state <= S_IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_adc_capture_packer.sv
// Bench for adc_capture_packer: one instance per pairing mode, checked against a model that
// derives each expected word from a per-cycle history of the samples that were driven.
module tb_adc_capture_packer;
    localparam int SW      = 8;
    localparam int NP      = 4;
    localparam int LW      = 16;
    localparam int DW      = 4;
    localparam int OW      = 2 * SW * NP;
    localparam int CYC_MAX = 4096;

    logic          dco     = 1'b0;
    logic          rst     = 1'b1;
    logic [SW-1:0] dr      = '0;
    logic [SW-1:0] df      = '0;
    logic          arm     = 1'b0;
    logic          abort   = 1'b0;
    logic          trig    = 1'b0;
    logic          wr_full = 1'b0;
    logic [LW-1:0] rec_len = '0;
    logic [DW-1:0] decim   = '0;
`ifdef ADC_TEST_PATTERN_EN
    logic          tp_sel  = 1'b0;
`endif
    logic [OW-1:0] wr_data0, wr_data1;
    logic          wr_en0, wr_en1, busy0, busy1, done0, done1, ovf0, ovf1;
    logic [LW-1:0] wcnt0, wcnt1;

    adc_capture_packer #(.SAMPLE_W(SW), .PAIRS(NP), .PAIR_ALIGN(1'b0), .LEN_W(LW), .DECIM_W(DW)) u_dut0 (
        .dco(dco), .rst(rst), .dr(dr), .df(df), .arm(arm), .abort(abort), .trig(trig),
        .rec_len(rec_len), .decim(decim), .wr_full(wr_full),
`ifdef ADC_TEST_PATTERN_EN
        .tp_sel(tp_sel),
`endif
        .wr_data(wr_data0), .wr_en(wr_en0), .busy(busy0), .done(done0),
        .overflow(ovf0), .word_cnt(wcnt0)
    );

    adc_capture_packer #(.SAMPLE_W(SW), .PAIRS(NP), .PAIR_ALIGN(1'b1), .LEN_W(LW), .DECIM_W(DW)) u_dut1 (
        .dco(dco), .rst(rst), .dr(dr), .df(df), .arm(arm), .abort(abort), .trig(trig),
        .rec_len(rec_len), .decim(decim), .wr_full(wr_full),
`ifdef ADC_TEST_PATTERN_EN
        .tp_sel(tp_sel),
`endif
        .wr_data(wr_data1), .wr_en(wr_en1), .busy(busy1), .done(done1),
        .overflow(ovf1), .word_cnt(wcnt1)
    );

    always #5 dco = ~dco;

    int            cyc       = 0;
    int            n_pass    = 0;
    int            n_checks  = 0;
    int            smode     = 0;
    int            ramp_base = 0;
    int            rel_cyc   = 0;
    bit            m_ovf     = 1'b0;
    bit            m_done    = 1'b0;
    logic [SW-1:0] hist_dr [CYC_MAX];
    logic [SW-1:0] hist_df [CYC_MAX];
    bit            full_at [CYC_MAX + 64];
    int            q0_c[$], q1_c[$];
    logic [OW-1:0] q0_d[$], q1_d[$];

    task automatic check(input string tag, input logic [OW-1:0] got, input logic [OW-1:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", tag, got, exp);
    endtask

    task automatic clear_queues();
        q0_c.delete(); q1_c.delete(); q0_d.delete(); q1_d.delete();
    endtask

    // Drive the inputs for edge number cyc, run that edge, then record writes away from the edge.
    task automatic tick();
        logic [SW-1:0] edr, edf;
        if (smode == 1) begin
            df = SW'(2 * (cyc - ramp_base));
            dr = SW'(2 * (cyc - ramp_base) + 1);
        end else begin
            dr = SW'($urandom);
            df = SW'($urandom);
        end
        edr = dr;
        edf = df;
`ifdef ADC_TEST_PATTERN_EN
        if (tp_sel) begin
            edf = SW'(2 * (cyc - rel_cyc));
            edr = edf + 1'b1;
        end
`endif
        wr_full      = full_at[cyc];
        hist_dr[cyc] = edr;
        hist_df[cyc] = edf;
        @(posedge dco);
        @(negedge dco);
        if (wr_en0) begin q0_c.push_back(cyc); q0_d.push_back(wr_data0); end
        if (wr_en1) begin q1_c.push_back(cyc); q1_d.push_back(wr_data1); end
        cyc++;
        if (cyc >= CYC_MAX) begin
            $display("FAIL cycle_budget: got %0d cycles, limit %0d", cyc, CYC_MAX);
            $fatal(1, "cycle budget exhausted");
        end
    endtask

    // Pair j of word k is the sample at cycle t0 + (k*NP + j)*(dec+1); pair 0 sits in the LSBs.
    function automatic logic [OW-1:0] exp_word(input int t0, input int k, input int dec, input bit align);
        logic [OW-1:0] w;
        int            c;
        w = '0;
        for (int j = 0; j < NP; j++) begin
            c = t0 + (k * NP + j) * (dec + 1);
            w[j*2*SW +: 2*SW] = {hist_dr[c], align ? hist_df[c-1] : hist_df[c]};
        end
        return w;
    endfunction

    task automatic check_record(input int t0, input int dec, input int nw, input bit [7:0] drop);
        int n_exp, idx, e;
        n_exp = 0;
        idx   = 0;
        for (int k = 0; k < nw; k++) if (!drop[k]) n_exp++;
        check("wr_en_count0", q0_c.size(), n_exp);
        check("wr_en_count1", q1_c.size(), n_exp);
        for (int k = 0; k < nw; k++) begin
            if (!drop[k]) begin
                e = t0 + ((k + 1) * NP - 1) * (dec + 1) + 1;
                if (idx < q0_c.size()) begin
                    check("wr_en_cycle0", q0_c[idx], e);
                    check("wr_data_align0", q0_d[idx], exp_word(t0, k, dec, 1'b0));
                end
                if (idx < q1_c.size()) begin
                    check("wr_en_cycle1", q1_c[idx], e);
                    check("wr_data_align1", q1_d[idx], exp_word(t0, k, dec, 1'b1));
                end
                idx++;
            end
        end
    endtask

    task automatic run_record(input int dec, input int rl, input int dly,
                              input bit [7:0] drop, input bit rnd_full, output int t0);
        int last;
        decim   = DW'(dec);
        rec_len = LW'(rl);
        t0      = cyc + 1 + dly;
        last    = t0 + (rl * NP - 1) * (dec + 1) + 1;
        if (smode == 1) ramp_base = t0 - 10;
        if (m_done) m_ovf = 1'b0;
        if (rnd_full)
            for (int c = t0; c <= last + 2; c++) full_at[c] = 1'($urandom_range(0, 1));
        for (int k = 0; k < rl; k++) begin
            full_at[t0 + ((k + 1) * NP - 1) * (dec + 1) + 1] = drop[k];
            if (drop[k]) m_ovf = 1'b1;
        end
        clear_queues();
        arm = 1'b1; tick(); arm = 1'b0;
        check("busy_after_arm", busy0, 1'b1);
        repeat (dly) tick();
        trig = 1'b1; tick(); trig = 1'b0;
        while (cyc <= last + 1) tick();
        check_record(t0, dec, rl, drop);
        check("done_end0", done0, 1'b1);
        check("done_end1", done1, 1'b1);
        check("busy_end", busy0, 1'b0);
        check("word_cnt_end", wcnt0, rl);
        check("overflow0", ovf0, m_ovf);
        check("overflow1", ovf1, m_ovf);
        m_done = 1'b1;
    endtask

    initial begin
        int t0, dly;

        // Reset state
        tick(); tick();
        check("rst_wr_en0", wr_en0, 1'b0);
        check("rst_wr_en1", wr_en1, 1'b0);
        check("rst_busy", busy0, 1'b0);
        check("rst_done", done0, 1'b0);
        check("rst_overflow", ovf0, 1'b0);
        check("rst_word_cnt", wcnt0, 0);
        check("rst_wr_data", wr_data0, 0);
        rst     = 1'b0;
        rel_cyc = cyc;
        tick();

        // Counting lanes, trigger at n=10, two-word record
        smode = 1;
        run_record(0, 2, 3, 8'h00, 1'b0, t0);
        if (q0_d.size() >= 2) begin
            check("t1_word0", q0_d[0], 64'h1B1A_1918_1716_1514);
            check("t1_word1", q0_d[1], 64'h2322_2120_1F1E_1D1C);
        end
        if (q1_d.size() >= 1) check("t2_word0_align", q1_d[0], 64'h1B18_1916_1714_1512);
        smode = 0;

        // Decimation by 2: last pair at t0+6, strobe after edge t0+7
        run_record(1, 1, 0, 8'h00, 1'b0, t0);
        if (q0_c.size() >= 1) check("decim_latency", q0_c[0] - t0, 7);

        // Randomised records with random back-pressure on non-emit cycles and random drops
        for (int i = 0; i < 10; i++)
            run_record($urandom_range(0, 2), $urandom_range(1, 3), $urandom_range(0, 3),
                       8'($urandom_range(0, 7)), 1'b1, t0);

        // Writer full during the second emit of a four-word record
        run_record(0, 4, 2, 8'b0000_0010, 1'b0, t0);
        check("drop_pulses", q0_c.size(), 3);
        arm = 1'b1; tick(); arm = 1'b0;
        m_done = 1'b0;
        m_ovf  = 1'b0;
        check("rearm_done", done0, 1'b0);
        check("rearm_overflow", ovf0, 1'b0);
        check("rearm_busy", busy0, 1'b1);

        // Abort together with arm two cycles after trigger
        clear_queues();
        rec_len = 2;
        decim   = 0;
        tick();
        trig = 1'b1; tick(); trig = 1'b0;
        tick();
        abort = 1'b1; arm = 1'b1; tick(); abort = 1'b0; arm = 1'b0;
        check("abort_busy", busy0, 1'b0);
        check("abort_done", done0, 1'b0);
        repeat (12) tick();
        check("abort_no_write0", q0_c.size(), 0);
        check("abort_no_write1", q1_c.size(), 0);
        run_record(0, 1, 1, 8'h00, 1'b1, t0);

        // Continuous mode: three words, still busy, then abort
        m_ovf   = 1'b0;
        decim   = 0;
        rec_len = 0;
        clear_queues();
        t0 = cyc + 1;
        for (int c = t0; c <= t0 + 14; c++)
            full_at[c] = ((c - t0) % NP == 0) ? 1'b0 : 1'($urandom_range(0, 1));
        arm = 1'b1; tick(); arm = 1'b0;
        trig = 1'b1; tick(); trig = 1'b0;
        while (cyc <= t0 + 12) tick();
        check_record(t0, 0, 3, 8'h00);
        check("cont_busy", busy0, 1'b1);
        check("cont_word_cnt", wcnt0, 3);
        check("cont_done", done0, 1'b0);
        abort = 1'b1; tick(); abort = 1'b0;
        check("cont_abort_busy", busy0, 1'b0);
        m_done = 1'b0;

        // Asynchronous reset in the middle of a capture
        decim   = 0;
        rec_len = 4;
        arm = 1'b1; tick(); arm = 1'b0;
        trig = 1'b1; tick(); trig = 1'b0;
        repeat (4) tick();
        check("pre_reset_wr_en", wr_en0, 1'b1);
        #2 rst = 1'b1;
        #1;
        check("async_rst_wr_en", wr_en0, 1'b0);
        check("async_rst_busy", busy0, 1'b0);
        check("async_rst_done", done0, 1'b0);
        check("async_rst_overflow", ovf0, 1'b0);
        check("async_rst_word_cnt", wcnt0, 0);
        tick();
        rst     = 1'b0;
        rel_cyc = cyc;
        m_ovf   = 1'b0;
        m_done  = 1'b0;
        clear_queues();
        trig = 1'b1; repeat (5) tick(); trig = 1'b0;
        check("trig_only_busy", busy0, 1'b0);
        check("trig_only_writes", q0_c.size(), 0);

`ifdef ADC_TEST_PATTERN_EN
        // Test pattern: trigger where the ramp is back at zero
        tp_sel = 1'b1;
        dly = (128 - ((cyc + 1 - rel_cyc) % 128)) % 128;
        run_record(0, 1, dly, 8'h00, 1'b0, t0);
        if (q0_d.size() >= 1) check("tp_word0", q0_d[0], 64'h0706_0504_0302_0100);
        tp_sel = 1'b0;
`else
        dly = 0;
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
